// File: rtl/ps2_scan_display.sv
// ps2_scan_display
//   PS/2 keyboard receive path for the keyboard demo. Deserialises 11-bit
//   PS/2 frames into scan codes and buffers them in a FIFO. The FIFO head is
//   mapped to lowercase ASCII. Make codes are counted. Six 7-segment digits
//   show scancode, ASCII and count.
// Ports
//   clk        system clock, rising edge
//   rst        synchronous active-high reset
//   ps2_clk    PS/2 clock pin (asynchronous)
//   ps2_data   PS/2 data pin (asynchronous)
//   next       pop FIFO head (1-cycle pulse), ignored when empty
//   scancode   FIFO head byte, 8'h00 when empty
//   asciicode  ASCII of scancode, 8'h00 if unmapped
//   ready      FIFO not empty
//   overflow   sticky: a valid frame arrived while the FIFO was full
//   count      number of make codes received, wraps
//   hex0..hex5 active-low 7-seg, bits[7:1]=a..g, bit0=DP (always off)
module ps2_scan_display #(
  parameter int FIFO_DEPTH = 8
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       ps2_clk,
  input  logic       ps2_data,
  input  logic       next,
  output logic [7:0] scancode,
  output logic [7:0] asciicode,
  output logic       ready,
  output logic       overflow,
  output logic [7:0] count,
  output logic [7:0] hex0,
  output logic [7:0] hex1,
  output logic [7:0] hex2,
  output logic [7:0] hex3,
  output logic [7:0] hex4,
  output logic [7:0] hex5
);

  localparam int PW = $clog2(FIFO_DEPTH);
  localparam logic [PW:0] DEPTH = FIFO_DEPTH[PW:0];

  logic [2:0]    clk_sync_q, clk_sync_d;
  logic [1:0]    data_sync_q, data_sync_d;
  logic [3:0]    bit_cnt_q, bit_cnt_d;
  logic [9:0]    shift_q, shift_d;     // [0]=start, [8:1]=data, [9]=parity
  logic [PW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [PW:0]   fill_q, fill_d;
  logic          overflow_q, overflow_d;
  logic [7:0]    count_q, count_d;
  logic          brk_q, brk_d, ext_q, ext_d;
  logic [7:0]    mem [FIFO_DEPTH];

  logic       fall, bit_in, push, pop, full, wr_en;
  logic [7:0] push_byte;

  function automatic logic [7:0] seg7(input logic [3:0] n);
    case (n)
      4'h0: seg7 = 8'h03;  4'h1: seg7 = 8'h9F;  4'h2: seg7 = 8'h25;  4'h3: seg7 = 8'h0D;
      4'h4: seg7 = 8'h99;  4'h5: seg7 = 8'h49;  4'h6: seg7 = 8'h41;  4'h7: seg7 = 8'h1F;
      4'h8: seg7 = 8'h01;  4'h9: seg7 = 8'h09;  4'hA: seg7 = 8'h11;  4'hB: seg7 = 8'hC1;
      4'hC: seg7 = 8'h63;  4'hD: seg7 = 8'h85;  4'hE: seg7 = 8'h61;  default: seg7 = 8'h71;
    endcase
  endfunction

  function automatic logic [7:0] to_ascii(input logic [7:0] s);
    case (s)
      8'h1C: to_ascii = 8'h61;  8'h32: to_ascii = 8'h62;  8'h21: to_ascii = 8'h63;
      8'h23: to_ascii = 8'h64;  8'h24: to_ascii = 8'h65;  8'h2B: to_ascii = 8'h66;
      8'h34: to_ascii = 8'h67;  8'h33: to_ascii = 8'h68;  8'h43: to_ascii = 8'h69;
      8'h3B: to_ascii = 8'h6A;  8'h42: to_ascii = 8'h6B;  8'h4B: to_ascii = 8'h6C;
      8'h3A: to_ascii = 8'h6D;  8'h31: to_ascii = 8'h6E;  8'h44: to_ascii = 8'h6F;
      8'h4D: to_ascii = 8'h70;  8'h15: to_ascii = 8'h71;  8'h2D: to_ascii = 8'h72;
      8'h1B: to_ascii = 8'h73;  8'h2C: to_ascii = 8'h74;  8'h3C: to_ascii = 8'h75;
      8'h2A: to_ascii = 8'h76;  8'h1D: to_ascii = 8'h77;  8'h22: to_ascii = 8'h78;
      8'h35: to_ascii = 8'h79;  8'h1A: to_ascii = 8'h7A;
      8'h45: to_ascii = 8'h30;  8'h16: to_ascii = 8'h31;  8'h1E: to_ascii = 8'h32;
      8'h26: to_ascii = 8'h33;  8'h25: to_ascii = 8'h34;  8'h2E: to_ascii = 8'h35;
      8'h36: to_ascii = 8'h36;  8'h3D: to_ascii = 8'h37;  8'h3E: to_ascii = 8'h38;
      8'h46: to_ascii = 8'h39;  8'h29: to_ascii = 8'h20;  8'h5A: to_ascii = 8'h0D;
      default: to_ascii = 8'h00;
    endcase
  endfunction

  always_comb begin
    // NOTE: every signal gets its default first so no path leaves it unassigned (no latch).
    clk_sync_d  = {clk_sync_q[1:0], ps2_clk};
    data_sync_d = {data_sync_q[0], ps2_data};
    bit_cnt_d   = bit_cnt_q;
    shift_d     = shift_q;
    wr_ptr_d    = wr_ptr_q;
    rd_ptr_d    = rd_ptr_q;
    fill_d      = fill_q;
    overflow_d  = overflow_q;
    count_d     = count_q;
    brk_d       = brk_q;
    ext_d       = ext_q;
    push        = 1'b0;
    push_byte   = shift_q[8:1];

    // Data uses one flop less, so bit_in lines up with the sampled clock stage.
    fall   = (clk_sync_q[2:1] == 2'b10);
    bit_in = data_sync_q[1];

    if (fall) begin
      if (bit_cnt_q == 4'd10) begin
        // Stop bit is bit_in itself; start/data/parity already shifted in.
        bit_cnt_d = 4'd0;
        push      = !shift_q[0] && bit_in && (^shift_q[9:1]);
      end else begin
        bit_cnt_d = bit_cnt_q + 4'd1;
        shift_d   = {bit_in, shift_q[9:1]};
      end
    end

    full  = (fill_q == DEPTH);
    pop   = next && (fill_q != '0);
    // A pop in the same cycle frees the slot a full FIFO needs.
    wr_en = push && (!full || pop);

    if (wr_en) wr_ptr_d = wr_ptr_q + 1'b1;
    if (pop)   rd_ptr_d = rd_ptr_q + 1'b1;
    case ({wr_en, pop})
      2'b10:   fill_d = fill_q + 1'b1;
      2'b01:   fill_d = fill_q - 1'b1;
      default: fill_d = fill_q;
    endcase
    if (push && !wr_en) overflow_d = 1'b1;

    // Key-press counting sees every valid frame, dropped or not.
    if (push) begin
      if (push_byte == 8'hF0) begin
        brk_d = 1'b1;
      end else if (push_byte == 8'hE0) begin
        ext_d = 1'b1;
      end else if (brk_q) begin
        brk_d = 1'b0;   // released key: not a press
        ext_d = 1'b0;
      end else begin
        count_d = count_q + 8'd1;
        ext_d   = 1'b0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      clk_sync_q  <= 3'b111;   // idle-high, so reset release is not seen as a falling edge
      data_sync_q <= 2'b11;
      bit_cnt_q   <= '0;
      shift_q     <= '0;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      fill_q      <= '0;
      overflow_q  <= 1'b0;
      count_q     <= '0;
      brk_q       <= 1'b0;
      ext_q       <= 1'b0;
    end else begin
      clk_sync_q  <= clk_sync_d;
      data_sync_q <= data_sync_d;
      bit_cnt_q   <= bit_cnt_d;
      shift_q     <= shift_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      fill_q      <= fill_d;
      overflow_q  <= overflow_d;
      count_q     <= count_d;
      brk_q       <= brk_d;
      ext_q       <= ext_d;
    end
  end

  // NOTE: storage is not reset; empty pointers keep stale entries invisible.
  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_ptr_q] <= push_byte;
  end

  assign ready     = (fill_q != '0);
  assign scancode  = ready ? mem[rd_ptr_q] : 8'h00;
  assign asciicode = to_ascii(scancode);
  assign overflow  = overflow_q;
  assign count     = count_q;
  assign hex0      = seg7(scancode[3:0]);
  assign hex1      = seg7(scancode[7:4]);
  assign hex2      = seg7(asciicode[3:0]);
  assign hex3      = seg7(asciicode[7:4]);
  assign hex4      = seg7(count_q[3:0]);
  assign hex5      = seg7(count_q[7:4]);

endmodule

// File: tb/tb_ps2_scan_display.sv
// Directed bench for ps2_scan_display: drives PS/2 frames on the pins and
// checks FIFO, ASCII mapping, key counting and 7-seg outputs.
module tb_ps2_scan_display;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       ps2_clk = 1'b1;
  logic       ps2_data = 1'b1;
  logic       next = 1'b0;
  logic [7:0] scancode, asciicode, count;
  logic       ready, overflow;
  logic [7:0] hex0, hex1, hex2, hex3, hex4, hex5;

  int errors = 0;
  int checks = 0;

  ps2_scan_display #(.FIFO_DEPTH(8)) dut (
    .clk(clk), .rst(rst), .ps2_clk(ps2_clk), .ps2_data(ps2_data), .next(next),
    .scancode(scancode), .asciicode(asciicode), .ready(ready), .overflow(overflow),
    .count(count), .hex0(hex0), .hex1(hex1), .hex2(hex2), .hex3(hex3),
    .hex4(hex4), .hex5(hex5)
  );

  always #5 clk = ~clk;

  // Stimulus changes and output sampling both happen on the falling clk edge.
  task automatic do_reset();
    ps2_clk = 1'b1; ps2_data = 1'b1; next = 1'b0; rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
  endtask

  // One PS/2 bit. With pop_here the next pulse lands on the cycle that
  // samples this falling edge (two sync stages after the pin drops).
  task automatic ps2_bit(input logic v, input bit pop_here);
    ps2_data = v;
    repeat (3) @(negedge clk);
    ps2_clk = 1'b0;
    if (pop_here) begin
      repeat (2) @(negedge clk);
      next = 1'b1;
      @(negedge clk);
      next = 1'b0;
      repeat (3) @(negedge clk);
    end else begin
      repeat (6) @(negedge clk);
    end
    ps2_clk = 1'b1;
    repeat (3) @(negedge clk);
  endtask

  task automatic send_frame(input logic [7:0] b, input bit bad_par, input bit pop_at_stop);
    logic par;
    par = ~(^b) ^ bad_par;
    ps2_bit(1'b0, 1'b0);
    for (int i = 0; i < 8; i++) ps2_bit(b[i], 1'b0);
    ps2_bit(par, 1'b0);
    ps2_bit(1'b1, pop_at_stop);
    ps2_data = 1'b1;
  endtask

  task automatic pop();
    next = 1'b1;
    @(negedge clk);
    next = 1'b0;
  endtask

  task automatic test_reset();
    logic [7:0] hx [6];
    do_reset();
    hx = '{hex0, hex1, hex2, hex3, hex4, hex5};
    checks++; if (ready !== 1'b0) begin errors++; $display("FAIL reset_ready got %b exp 0", ready); end
    checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL reset_overflow got %b exp 0", overflow); end
    checks++; if (count !== 8'h00) begin errors++; $display("FAIL reset_count got %h exp 00", count); end
    checks++; if (scancode !== 8'h00) begin errors++; $display("FAIL reset_scancode got %h exp 00", scancode); end
    checks++; if (asciicode !== 8'h00) begin errors++; $display("FAIL reset_ascii got %h exp 00", asciicode); end
    for (int i = 0; i < 6; i++) begin
      checks++;
      if (hx[i] !== 8'h03) begin errors++; $display("FAIL reset_hex%0d got %h exp 03", i, hx[i]); end
    end
  endtask

  task automatic test_single();
    do_reset();
    send_frame(8'h1C, 1'b0, 1'b0);
    checks++; if (ready !== 1'b1) begin errors++; $display("FAIL single_ready got %b exp 1", ready); end
    checks++; if (scancode !== 8'h1C) begin errors++; $display("FAIL single_scancode got %h exp 1c", scancode); end
    checks++; if (asciicode !== 8'h61) begin errors++; $display("FAIL single_ascii got %h exp 61", asciicode); end
    checks++; if (count !== 8'h01) begin errors++; $display("FAIL single_count got %h exp 01", count); end
    checks++; if (hex0 !== 8'h63) begin errors++; $display("FAIL single_hex0 got %h exp 63", hex0); end
    checks++; if (hex1 !== 8'h9F) begin errors++; $display("FAIL single_hex1 got %h exp 9f", hex1); end
    checks++; if (hex2 !== 8'h9F) begin errors++; $display("FAIL single_hex2 got %h exp 9f", hex2); end
    checks++; if (hex3 !== 8'h41) begin errors++; $display("FAIL single_hex3 got %h exp 41", hex3); end
    checks++; if (hex4 !== 8'h9F) begin errors++; $display("FAIL single_hex4 got %h exp 9f", hex4); end
    checks++; if (hex5 !== 8'h03) begin errors++; $display("FAIL single_hex5 got %h exp 03", hex5); end
  endtask

  task automatic test_break();
    logic [7:0] exp_q [3] = '{8'h1C, 8'hF0, 8'h1C};
    do_reset();
    for (int i = 0; i < 3; i++) send_frame(exp_q[i], 1'b0, 1'b0);
    checks++; if (count !== 8'h01) begin errors++; $display("FAIL break_count got %h exp 01", count); end
    for (int i = 0; i < 3; i++) begin
      checks++;
      if (scancode !== exp_q[i]) begin errors++; $display("FAIL break_head%0d got %h exp %h", i, scancode, exp_q[i]); end
      pop();
    end
    checks++; if (ready !== 1'b0) begin errors++; $display("FAIL break_empty_ready got %b exp 0", ready); end
    checks++; if (scancode !== 8'h00) begin errors++; $display("FAIL break_empty_scancode got %h exp 00", scancode); end
    pop();  // pop on empty: no effect
    checks++; if (ready !== 1'b0) begin errors++; $display("FAIL empty_pop_ready got %b exp 0", ready); end
    send_frame(8'h2B, 1'b0, 1'b0);
    checks++; if (scancode !== 8'h2B) begin errors++; $display("FAIL after_empty_pop got %h exp 2b", scancode); end
    checks++; if (asciicode !== 8'h66) begin errors++; $display("FAIL after_empty_ascii got %h exp 66", asciicode); end
  endtask

  task automatic test_bad_parity();
    do_reset();
    send_frame(8'h45, 1'b1, 1'b0);
    checks++; if (ready !== 1'b0) begin errors++; $display("FAIL badpar_ready got %b exp 0", ready); end
    checks++; if (count !== 8'h00) begin errors++; $display("FAIL badpar_count got %h exp 00", count); end
    checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL badpar_overflow got %b exp 0", overflow); end
    send_frame(8'h45, 1'b0, 1'b0);
    checks++; if (asciicode !== 8'h30) begin errors++; $display("FAIL goodpar_ascii got %h exp 30", asciicode); end
    checks++; if (count !== 8'h01) begin errors++; $display("FAIL goodpar_count got %h exp 01", count); end
  endtask

  // Fill 8, drop the 9th, then push a 10th with a simultaneous pop.
  task automatic test_overflow();
    logic [7:0] codes [8] = '{8'h15, 8'h1D, 8'h24, 8'h2D, 8'h2C, 8'h35, 8'h3C, 8'h43};
    do_reset();
    for (int i = 0; i < 8; i++) send_frame(codes[i], 1'b0, 1'b0);
    checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL full_no_overflow got %b exp 0", overflow); end
    send_frame(8'h44, 1'b0, 1'b0);
    checks++; if (overflow !== 1'b1) begin errors++; $display("FAIL overflow_set got %b exp 1", overflow); end
    checks++; if (count !== 8'h09) begin errors++; $display("FAIL overflow_count got %h exp 09", count); end
    checks++; if (scancode !== 8'h15) begin errors++; $display("FAIL overflow_head got %h exp 15", scancode); end
    send_frame(8'h4D, 1'b0, 1'b1);
    for (int i = 1; i < 8; i++) begin
      checks++;
      if (scancode !== codes[i]) begin errors++; $display("FAIL ovf_drain%0d got %h exp %h", i, scancode, codes[i]); end
      pop();
    end
    checks++; if (scancode !== 8'h4D) begin errors++; $display("FAIL ovf_tenth got %h exp 4d", scancode); end
    pop();
    checks++; if (ready !== 1'b0) begin errors++; $display("FAIL ovf_drained_ready got %b exp 0", ready); end
    checks++; if (overflow !== 1'b1) begin errors++; $display("FAIL overflow_sticky got %b exp 1", overflow); end
  endtask

  // Push and pop on the same cycle when full: nothing dropped, no flag.
  task automatic test_full_push_pop();
    logic [7:0] codes [9] = '{8'h15, 8'h1D, 8'h24, 8'h2D, 8'h2C, 8'h35, 8'h3C, 8'h43, 8'h44};
    do_reset();
    for (int i = 0; i < 8; i++) send_frame(codes[i], 1'b0, 1'b0);
    send_frame(codes[8], 1'b0, 1'b1);
    checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL pushpop_overflow got %b exp 0", overflow); end
    for (int i = 1; i < 9; i++) begin
      checks++;
      if (scancode !== codes[i]) begin errors++; $display("FAIL pushpop_drain%0d got %h exp %h", i, scancode, codes[i]); end
      pop();
    end
    checks++; if (ready !== 1'b0) begin errors++; $display("FAIL pushpop_empty got %b exp 0", ready); end
  endtask

  // Reset in the middle of a frame; the next frame must decode cleanly.
  task automatic test_mid_frame_reset();
    do_reset();
    ps2_bit(1'b0, 1'b0);
    ps2_bit(1'b1, 1'b0);
    ps2_bit(1'b1, 1'b0);
    do_reset();
    send_frame(8'h5A, 1'b0, 1'b0);
    checks++; if (scancode !== 8'h5A) begin errors++; $display("FAIL midrst_scancode got %h exp 5a", scancode); end
    checks++; if (asciicode !== 8'h0D) begin errors++; $display("FAIL midrst_ascii got %h exp 0d", asciicode); end
  endtask

  task automatic test_count_wrap();
    do_reset();
    for (int i = 0; i < 256; i++) begin
      send_frame(8'h16, 1'b0, 1'b0);
      pop();
      if (i == 254) begin
        checks++; if (count !== 8'hFF) begin errors++; $display("FAIL wrap_ff got %h exp ff", count); end
        checks++; if (hex4 !== 8'h71 || hex5 !== 8'h71) begin
          errors++; $display("FAIL wrap_ff_hex got %h/%h exp 71/71", hex5, hex4);
        end
      end
    end
    checks++; if (count !== 8'h00) begin errors++; $display("FAIL wrap_count got %h exp 00", count); end
    checks++; if (hex5 !== 8'h03 || hex4 !== 8'h03) begin
      errors++; $display("FAIL wrap_hex got %h/%h exp 03/03", hex5, hex4);
    end
    checks++; if (ready !== 1'b0) begin errors++; $display("FAIL wrap_ready got %b exp 0", ready); end
  endtask

  initial begin
    test_reset();
    test_single();
    test_break();
    test_bad_parity();
    test_overflow();
    test_full_push_pop();
    test_mid_frame_reset();
    test_count_wrap();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
